lcd_ctrl_gen: RTL and testbench
===============================

Name: lcd_ctrl_gen

Overview:
- Parametrised successor to the team's DE2-115 character LCD driver, targeting HD44780-compatible modules.
- Generalised in geometry: ROWS 1/2/4, arbitrary COLS.
- Clients address characters by row/col. The block maps these to DDRAM addresses, tracks the cursor so it can skip redundant set-address commands, and supports clear/home ops.
- All timing is cycle-count parameters.
- Sits between game/UI logic and the board LCD pins, with a valid/ready request port.

Parameters:
ROWS, 2, display rows (1, 2 or 4)
COLS, 16, display columns (1..40)
BOOT_CYC, 960000, power-on wait before the first command (19.2 ms @ 50 MHz)
CLR_CYC, 76500, post-command wait for clear (0x01) and home (0x02)
CMD_CYC, 2150, post-write wait for all other commands and data (43 us)
AS_CYC, 2, RS/DATA setup cycles before EN rises
EN_CYC, 12, EN high width in cycles

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  block idle, request accepted when i_valid && o_ready
i_op  in  2  00 write char, 01 clear, 10 home, 11 raw command
i_row  in  max(1,$clog2(ROWS))  target row (op 00)
i_col  in  $clog2(COLS+1)  target column (op 00)
i_data  in  8  character code (op 00) or command byte (op 11)
o_err  out  1  one-cycle pulse: request rejected
LCD_DATA  out  8  LCD bus
LCD_RS  out  1  0 command, 1 data
LCD_EN  out  1  enable strobe
LCD_RW  out  1  constant 0
LCD_ON  out  1  constant 1
LCD_BLON  out  1  constant 1

Behaviour:
- Reset (i_rst_n low at a clock edge, including mid-transfer):
  - LCD_EN=0, LCD_RS=0, LCD_DATA=0, o_ready=0, o_err=0.
  - Cursor tracking invalid; state goes to BOOT.
  - Full boot sequence always re-runs.
- States:
  - BOOT: wait BOOT_CYC.
  - INIT: four commands in order: function set (0x38, or 0x30 when ROWS==1), display on 0x0C, clear 0x01, entry mode 0x06.
  - IDLE, SETUP, STROBE, WAIT.
- Byte transfer:
  - SETUP drives RS/DATA with EN=0 for AS_CYC cycles.
  - STROBE holds EN=1 for exactly EN_CYC cycles, with RS/DATA stable.
  - EN falls, then WAIT for CMD_CYC (CLR_CYC for 0x01 and 0x02).
  - LCD_DATA/RS hold their last value until the next SETUP.
- o_ready is high only in IDLE.
  - First asserted the cycle after the INIT clear/entry-mode waits complete.
  - Deasserts the cycle after acceptance.
  - Inputs are sampled only at acceptance.
- Row base addresses: row0 0x00, row1 0x40, row2 COLS, row3 0x40+COLS. DDRAM address = base + col.
- Op 00 (write char):
  - If the tracked cursor is valid and equals the target address, one data write only.
  - Otherwise, set-DDRAM command (0x80|addr) then the data write.
  - After the data write, cursor = addr+1. Tracking is invalid if col was COLS-1, i.e. no wrap assumption across rows.
- Op 01: 0x01, wait CLR_CYC, cursor valid = 0x00.
- Op 10: 0x02, wait CLR_CYC, cursor valid = 0x00.
- Op 11: see optional feature.
- Range check: i_row>=ROWS or i_col>=COLS on op 00 means the request is accepted and dropped.
  - o_err pulses the cycle after acceptance.
  - o_ready returns the following cycle; no bus activity.
- i_valid while not ready is ignored, with no error. Requesters must hold until o_ready.
- Counters are sized to the largest delay parameter; all counts are exact, with no off-by-one.

Optional Feature:
- LCD_RAWCMD_EN defined: op 11 writes i_data as a command (RS=0).
  - Wait is CLR_CYC if i_data is 0x01 or 0x02, else CMD_CYC.
  - Cursor tracking becomes invalid.
- LCD_RAWCMD_EN undefined: op 11 is accepted and rejected. o_err pulses, no bus activity, cursor tracking unchanged.

Test Plan:
All tests use bench parameters BOOT_CYC=100, CLR_CYC=40, CMD_CYC=10, AS_CYC=2, EN_CYC=3.
- Boot: release reset -> EN strobes carry 0x38, 0x0C, 0x01, 0x06 with RS=0. First EN rise is no earlier than 100+2 cycles after reset release. Each EN pulse is exactly 3 cycles wide. o_ready rises after the final 10-cycle wait.
- Sequential chars: write 'A' at (0,0) then 'B' at (0,1) -> strobes 0x80, 0x41 (RS=1), then 0x42 only (no address command).
- Row mapping, ROWS=4 COLS=20: write at (2,5) -> command 0x99. Write at (3,0) -> command 0xD4.
- Wrap and clear: write at (0,15), then (1,0) -> both preceded by address commands 0x8F and 0xC0. Op 01 -> 0x01 with a 40-cycle wait. A following write at (0,0) emits data only.
- Errors: op 00 with col=16 (COLS=16) -> o_err pulses for one cycle, no EN activity. Op 11 with the macro off -> o_err; with the macro on, i_data=0x18 -> RS=0 strobe of 0x18, and the next write emits an address command.
- Reset mid-strobe: deassert i_rst_n while LCD_EN=1 -> EN=0 and o_ready=0 on the next edge, and the full boot sequence re-runs.

Source files
------------

// File: rtl/lcd_ctrl_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl_gen_if
// Purpose  : Request port bundle for lcd_ctrl_gen (valid/ready, op, position,
//            data byte, reject pulse).
// Revision : 1.0  initial release
// ============================================================================
interface lcd_ctrl_gen_if #(
  parameter int ROWS = 2,
  parameter int COLS = 16
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = $clog2(COLS + 1);

  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [ROW_W-1:0] i_row;
  logic [COL_W-1:0] i_col;
  logic [7:0]       i_data;
  logic             o_err;

  modport master (output i_valid, i_op, i_row, i_col, i_data,
                  input  o_ready, o_err);
  modport slave  (input  i_valid, i_op, i_row, i_col, i_data,
                  output o_ready, o_err);
endinterface
`default_nettype wire

// File: rtl/lcd_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl_gen
// Purpose  : HD44780 character LCD driver. Boots the panel, maps row/col to
//            DDRAM addresses, skips redundant set-address commands by tracking
//            the cursor, and sequences setup/strobe/wait timing per byte.
// Options  : define LCD_RAWCMD_EN to let op 11 write i_data as a raw command;
//            otherwise op 11 is rejected with o_err.
// Revision : 1.0  initial release
// ============================================================================
module lcd_ctrl_gen #(
  parameter int ROWS     = 2,
  parameter int COLS     = 16,
  parameter int BOOT_CYC = 960000,
  parameter int CLR_CYC  = 76500,
  parameter int CMD_CYC  = 2150,
  parameter int AS_CYC   = 2,
  parameter int EN_CYC   = 12
) (
  input  wire logic     i_clk,
  input  wire logic     i_rst_n,
  lcd_ctrl_gen_if.slave bus,
  output logic [7:0]    LCD_DATA,
  output logic          LCD_RS,
  output logic          LCD_EN,
  output logic          LCD_RW,
  output logic          LCD_ON,
  output logic          LCD_BLON
);

  // Counter must hold the largest of all delay loads.
  localparam int c_max_ab  = (BOOT_CYC > CLR_CYC) ? BOOT_CYC : CLR_CYC;
  localparam int c_max_cd  = (CMD_CYC > AS_CYC) ? CMD_CYC : AS_CYC;
  localparam int c_max_abc = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_max_dly = (c_max_abc > EN_CYC) ? c_max_abc : EN_CYC;
  localparam int c_cnt_w   = $clog2(c_max_dly + 1);

  localparam logic [c_cnt_w-1:0] c_boot_ld = c_cnt_w'(BOOT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_clr_ld  = c_cnt_w'(CLR_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cmd_ld  = c_cnt_w'(CMD_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_as_ld   = c_cnt_w'(AS_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_en_ld   = c_cnt_w'(EN_CYC - 1);
  localparam logic [7:0]         c_fn_set  = (ROWS == 1) ? 8'h30 : 8'h38;
  localparam logic [6:0]         c_cols7   = 7'(COLS);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_SETUP  = 3'd3,
    S_STROBE = 3'd4,
    S_WAIT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t               r_state, w_state;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt;
  logic [7:0]           r_data, w_data;
  logic                 r_rs, w_rs;
  logic [1:0]           r_init_idx, w_init_idx;
  logic                 r_init, w_init;
  logic                 r_pend_vld, w_pend_vld;
  logic [7:0]           r_pend_byte, w_pend_byte;
  logic                 r_cur_vld, w_cur_vld;
  logic [6:0]           r_cur_addr, w_cur_addr;

  logic [1:0]           w_row2;
  logic [6:0]           w_addr;
  logic                 w_bad;
  logic                 w_last_col;
  logic                 w_long;
  logic [7:0]           w_init_cmd;

  // Request decode: DDRAM address, range check, last-column detect.
  always_comb begin
    w_row2     = 2'(bus.i_row);
    w_addr     = (w_row2[0] ? 7'h40 : 7'h00) + (w_row2[1] ? c_cols7 : 7'h00)
                 + 7'(bus.i_col);
    w_bad      = (32'(bus.i_row) >= ROWS) || (32'(bus.i_col) >= COLS);
    w_last_col = (32'(bus.i_col) == 32'(COLS - 1));
    w_long     = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02));
    case (r_init_idx)
      2'd0:    w_init_cmd = c_fn_set;
      2'd1:    w_init_cmd = 8'h0C;
      2'd2:    w_init_cmd = 8'h01;
      default: w_init_cmd = 8'h06;
    endcase
  end

  // Next-state, byte sequencing and cursor tracking.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_data      = r_data;
    w_rs        = r_rs;
    w_init_idx  = r_init_idx;
    w_init      = r_init;
    w_pend_vld  = r_pend_vld;
    w_pend_byte = r_pend_byte;
    w_cur_vld   = r_cur_vld;
    w_cur_addr  = r_cur_addr;
    case (r_state)
      S_BOOT: begin
        if (r_cnt == '0) w_state = S_INIT;
        else             w_cnt   = r_cnt - 1'b1;
      end
      S_INIT: begin
        w_state = S_SETUP;
        w_cnt   = c_as_ld;
        w_data  = w_init_cmd;
        w_rs    = 1'b0;
      end
      S_IDLE: begin
        if (bus.i_valid) begin
          case (bus.i_op)
            2'b00: begin
              if (w_bad) begin
                w_state = S_ERR;
              end else begin
                w_state = S_SETUP;
                w_cnt   = c_as_ld;
                if (r_cur_vld && (r_cur_addr == w_addr)) begin
                  w_data     = bus.i_data;
                  w_rs       = 1'b1;
                  w_pend_vld = 1'b0;
                end else begin
                  w_data      = 8'h80 | {1'b0, w_addr};
                  w_rs        = 1'b0;
                  w_pend_vld  = 1'b1;
                  w_pend_byte = bus.i_data;
                end
                // No assumption about where the panel moves past the last column.
                w_cur_vld  = !w_last_col;
                w_cur_addr = w_addr + 7'd1;
              end
            end
            2'b01, 2'b10: begin
              w_state    = S_SETUP;
              w_cnt      = c_as_ld;
              w_data     = {6'b0, bus.i_op};
              w_rs       = 1'b0;
              w_pend_vld = 1'b0;
              w_cur_vld  = 1'b1;
              w_cur_addr = 7'h00;
            end
            default: begin
`ifdef LCD_RAWCMD_EN
              w_state    = S_SETUP;
              w_cnt      = c_as_ld;
              w_data     = bus.i_data;
              w_rs       = 1'b0;
              w_pend_vld = 1'b0;
              w_cur_vld  = 1'b0;
`else
              w_state = S_ERR;
`endif
            end
          endcase
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state = S_STROBE;
          w_cnt   = c_en_ld;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_state = S_WAIT;
          w_cnt   = w_long ? c_clr_ld : c_cmd_ld;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else if (r_pend_vld) begin
          w_state    = S_SETUP;
          w_cnt      = c_as_ld;
          w_data     = r_pend_byte;
          w_rs       = 1'b1;
          w_pend_vld = 1'b0;
        end else if (r_init && (r_init_idx != 2'd3)) begin
          w_state    = S_INIT;
          w_init_idx = r_init_idx + 2'd1;
        end else begin
          w_state = S_IDLE;
          w_init  = 1'b0;
        end
      end
      S_ERR:   w_state = S_IDLE;
      default: w_state = S_BOOT;
    endcase
  end

  // State and datapath registers; reset always restarts the boot sequence.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_BOOT;
      r_cnt       <= c_boot_ld;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_init_idx  <= 2'd0;
      r_init      <= 1'b1;
      r_pend_vld  <= 1'b0;
      r_pend_byte <= 8'h00;
      r_cur_vld   <= 1'b0;
      r_cur_addr  <= 7'h00;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_data      <= w_data;
      r_rs        <= w_rs;
      r_init_idx  <= w_init_idx;
      r_init      <= w_init;
      r_pend_vld  <= w_pend_vld;
      r_pend_byte <= w_pend_byte;
      r_cur_vld   <= w_cur_vld;
      r_cur_addr  <= w_cur_addr;
    end
  end

  assign bus.o_ready = (r_state == S_IDLE);
  assign bus.o_err   = (r_state == S_ERR);
  assign LCD_EN      = (r_state == S_STROBE);
  assign LCD_DATA    = r_data;
  assign LCD_RS      = r_rs;
  assign LCD_RW      = 1'b0;
  assign LCD_ON      = 1'b1;
  assign LCD_BLON    = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_ctrl_gen
// Purpose  : Scoreboard bench for lcd_ctrl_gen (4x20 geometry, short delays).
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_ctrl_gen;
  localparam int ROWS = 4, COLS = 20;
  localparam int BOOT_CYC = 100, CLR_CYC = 40, CMD_CYC = 10, AS_CYC = 2, EN_CYC = 3;

  typedef struct packed { logic rs; logic [7:0] data; } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_at_edge = 1'b1;
  int   cyc = 0;
  logic [7:0] lcd_data;
  logic lcd_rs, lcd_en, lcd_rw, lcd_on, lcd_blon;

  ev_t exp_q[$];
  int  err_q[$];
  int  n_vec = 0, n_fail = 0;
  bit  cv = 1'b0;
  int  ca = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  lcd_ctrl_gen_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  lcd_ctrl_gen #(.ROWS(ROWS), .COLS(COLS), .BOOT_CYC(BOOT_CYC), .CLR_CYC(CLR_CYC),
                 .CMD_CYC(CMD_CYC), .AS_CYC(AS_CYC), .EN_CYC(EN_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_EN(lcd_en),
    .LCD_RW(lcd_rw), .LCD_ON(lcd_on), .LCD_BLON(lcd_blon));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int req_min);
    n_vec++;
    if (act < req_min) begin
      n_fail++;
      $display("FAIL %s: got %0d, required at least %0d", name, act, req_min);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected bus bytes / rejections from the request rules.
  function automatic void model(input int op, input int row, input int col, input logic [7:0] data);
    int base[4];
    int addr;
    base[0] = 0; base[1] = 'h40; base[2] = COLS; base[3] = 'h40 + COLS;
    case (op)
      0: begin
        if (row >= ROWS || col >= COLS) begin
          err_q.push_back(cyc);
        end else begin
          addr = base[row] + col;
          if (!(cv && ca == addr)) exp_q.push_back('{1'b0, 8'('h80 | addr)});
          exp_q.push_back('{1'b1, data});
          if (col == COLS - 1) cv = 1'b0;
          else begin cv = 1'b1; ca = addr + 1; end
        end
      end
      1, 2: begin
        exp_q.push_back('{1'b0, 8'(op)});
        cv = 1'b1; ca = 0;
      end
      default: begin
`ifdef LCD_RAWCMD_EN
        exp_q.push_back('{1'b0, data});
        cv = 1'b0;
`else
        err_q.push_back(cyc);
`endif
      end
    endcase
  endfunction

  task automatic push_boot();
    exp_q.push_back('{1'b0, 8'h38});
    exp_q.push_back('{1'b0, 8'h0C});
    exp_q.push_back('{1'b0, 8'h01});
    exp_q.push_back('{1'b0, 8'h06});
    cv = 1'b0;
  endtask

  task automatic send(input int op, input int row, input int col, input logic [7:0] data);
    int budget;
    bus.i_op = 2'(op); bus.i_row = 2'(row); bus.i_col = 5'(col); bus.i_data = data;
    bus.i_valid = 1'b1;
    budget = 0;
    while (!bus.o_ready && budget < 5000) begin tick(); budget++; end
    if (!bus.o_ready) begin
      n_vec++; n_fail++;
      $display("FAIL ready_timeout: o_ready still 0 after %0d cycles, required 1", budget);
      bus.i_valid = 1'b0;
      return;
    end
    tick();
    bus.i_valid = 1'b0;
    model(op, row, col, data);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || !bus.o_ready) && b < 20000) begin
      tick(); b++;
    end
    if (b >= 20000) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: %0d strobes and %0d errors outstanding, required 0",
               exp_q.size(), err_q.size());
    end
    tick(); tick();
  endtask

  // Monitor: observes the LCD pins and o_err, checks timing and pops expectations.
  initial begin
    logic       en_q, err_prev, await_rdy, seen_rise;
    int         en_w, stab, gap, boot_n, last_wait;
    logic [8:0] prev_bus, strobe_bus;
    ev_t        cur;
    en_q = 0; err_prev = 0; await_rdy = 0; seen_rise = 0;
    en_w = 0; stab = 0; gap = 0; boot_n = 0; last_wait = CMD_CYC;
    prev_bus = '0; strobe_bus = '0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_err", bus.o_err, 0);
        en_q = 0; err_prev = 0; await_rdy = 0; seen_rise = 0;
        en_w = 0; stab = 0; gap = 0; boot_n = 0;
        prev_bus = {lcd_rs, lcd_data};
      end else begin
        if ({lcd_rs, lcd_data} == prev_bus) stab++;
        else stab = 1;
        prev_bus = {lcd_rs, lcd_data};
        if (lcd_en && !en_q) begin
          if (!seen_rise) begin
            chk_ge("boot_delay", boot_n, BOOT_CYC + AS_CYC);
            seen_rise = 1;
          end
          chk_ge("setup_cycles", stab - 1, AS_CYC);
          chk("rw_const", {lcd_rw, lcd_on, lcd_blon}, 3'b011);
          if (exp_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_strobe: got rs=%0b data=%0h, required no strobe", lcd_rs, lcd_data);
            cur = '{lcd_rs, lcd_data};
          end else begin
            cur = exp_q.pop_front();
            chk("strobe_rs", lcd_rs, cur.rs);
            chk("strobe_data", lcd_data, cur.data);
          end
          last_wait = (!cur.rs && (cur.data == 8'h01 || cur.data == 8'h02)) ? CLR_CYC : CMD_CYC;
          strobe_bus = {lcd_rs, lcd_data};
          en_w = 1; await_rdy = 0;
        end else if (lcd_en) begin
          en_w++;
          chk("strobe_stable", {lcd_rs, lcd_data}, strobe_bus);
        end else if (en_q) begin
          chk("en_width", en_w, EN_CYC);
          gap = 1; await_rdy = 1;
        end else if (await_rdy) begin
          if (bus.o_ready) begin
            chk("wait_cycles", gap, last_wait);
            await_rdy = 0;
          end else begin
            gap++;
          end
        end
        if (!seen_rise) boot_n++;
        if (bus.o_err) begin
          chk("err_single", err_prev, 0);
          chk("err_ready_low", bus.o_ready, 0);
          if (err_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_err: got o_err=1, required 0");
          end else begin
            chk("err_cycle", cyc, err_q.pop_front());
          end
        end
        err_prev = bus.o_err;
        en_q = lcd_en;
      end
    end
  end

  // Stimulus
  initial begin
    int b, op, row, col, r, lrow, lcol;
    bus.i_valid = 0; bus.i_op = 0; bus.i_row = 0; bus.i_col = 0; bus.i_data = 0;
    rst_n = 0;
    repeat (3) tick();
    push_boot();
    rst_n = 1;
    drain();

    send(0, 0, 0, "A");  send(0, 0, 1, "B");
    send(0, 2, 5, 8'h31); send(0, 3, 0, 8'h32);
    send(0, 0, 15, 8'h33); send(0, 1, 0, 8'h34);
    send(1, 0, 0, 8'h00); send(0, 0, 0, 8'h55);
    send(0, 0, 19, 8'h36); send(0, 2, 0, 8'h37);
    send(0, 1, COLS, 8'h38);
    send(3, 0, 0, 8'h18); send(0, 1, 3, 8'h39);
    send(2, 0, 0, 8'h00); send(0, 0, 0, 8'h3A);
    drain();

    lrow = 0; lcol = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 6) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      row = $urandom_range(0, ROWS - 1);
      col = $urandom_range(0, COLS);
      if ($urandom_range(0, 1) == 1 && lcol + 1 < COLS) begin
        row = lrow; col = lcol + 1;
      end
      send(op, row, col, 8'($urandom_range(0, 255)));
      lrow = row; lcol = (col < COLS) ? col : 0;
    end
    drain();

    send(0, 1, 7, 8'h5A);
    b = 0;
    while (!lcd_en && b < 500) begin tick(); b++; end
    if (!lcd_en) begin
      n_vec++; n_fail++;
      $display("FAIL en_timeout: LCD_EN still 0, required 1");
    end
    rst_n = 0;
    tick(); tick();
    exp_q.delete(); err_q.delete();
    push_boot();
    tick();
    rst_n = 1;
    drain();
    send(0, 3, 19, 8'h61); send(0, 0, 0, 8'h62); send(0, 0, 1, 8'h63);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
